// File: rtl/spi_reg_sequencer.sv
// Sensor register command sequencer: turns one read/write command into a
// 4-byte SPI frame driven through the SPI master core's register port.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | waiting for cmd_valid; cmd_ready high
// S_SSO_ON   | write ctrl (addr 3) = 0x0400: force SS_n low, IRQs off
// S_CLR_STAT | write status (addr 2) = 0: clear EOP/RRDY/ROE/TOE
// S_WR_DATA  | write txdata (addr 1) = current frame byte
// S_POLL     | read status (addr 2) until RRDY (bit 7) or timeout
// S_RD_RX    | read rxdata (addr 0); byte 3 lands in rsp_rdata, then
//            | picks the next byte or S_SSO_OFF (the zero-cycle NEXT step)
// S_SSO_OFF  | write ctrl (addr 3) = 0: release SS_n
// S_DONE     | one-cycle rsp_valid
//
// Every bus access lasts 3 cycles: phase 0/1 strobe active, phase 2 idle gap.
module spi_reg_sequencer #(
  parameter logic [7:0]  WR_OPCODE    = 8'h02,
  parameter logic [7:0]  RD_OPCODE    = 8'h82,
  parameter int unsigned POLL_TIMEOUT = 4096,
  parameter int unsigned TO_W         = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rnw,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_error,
  output logic        spi_select,
  output logic [2:0]  spi_mem_addr,
  output logic        spi_read_n,
  output logic        spi_write_n,
  output logic [15:0] spi_data_from_cpu,
  input  logic [15:0] spi_data_to_cpu
);

  typedef enum logic [2:0] {
    S_IDLE, S_SSO_ON, S_CLR_STAT, S_WR_DATA, S_POLL, S_RD_RX, S_SSO_OFF, S_DONE
  } state_t;

  // Poll budget runs as a down-counter: loaded with the last index, the read
  // that finds it at zero is the final permitted attempt.
  localparam logic [TO_W-1:0] POLL_LAST = TO_W'(POLL_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [1:0]      phase_q, phase_d;
  logic [1:0]      idx_q, idx_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            rrdy_q, rrdy_d;
  logic            err_q, err_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            rnw_q, rnw_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;

  logic            in_access, strobe_on, acc_end, acc_rd;
  logic [2:0]      acc_addr;
  logic [15:0]     acc_data;
  logic [7:0]      cur_byte;
  logic            unused_data_hi;

  assign in_access = state_q inside {S_SSO_ON, S_CLR_STAT, S_WR_DATA, S_POLL, S_RD_RX, S_SSO_OFF};
  assign strobe_on = in_access && (phase_q != 2'd2);
  assign acc_end   = in_access && (phase_q == 2'd2);

  assign cmd_ready      = (state_q == S_IDLE);
  assign rsp_valid      = (state_q == S_DONE);
  assign rsp_rdata      = rdata_q;
  assign rsp_error      = err_q;
  assign unused_data_hi = ^spi_data_to_cpu[15:8];

  // Select the frame byte for the current index; read frames carry a zero
  // dummy in byte 3 because wdata is zeroed at accept.
  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      2'd0: cur_byte = rnw_q ? RD_OPCODE : WR_OPCODE;
      2'd1: cur_byte = addr_q[15:8];
      2'd2: cur_byte = addr_q[7:0];
      default: cur_byte = wdata_q;
    endcase
  end

  // Decode the register access for the current state; address and data are
  // zero whenever no strobe is active.
  always_comb begin
    acc_addr = 3'd0;
    acc_data = 16'h0000;
    acc_rd   = 1'b0;
    case (state_q)
      S_SSO_ON:   begin acc_addr = 3'd3; acc_data = 16'h0400; end
      S_CLR_STAT: begin acc_addr = 3'd2; acc_data = 16'h0000; end
      S_WR_DATA:  begin acc_addr = 3'd1; acc_data = {8'h00, cur_byte}; end
      S_POLL:     begin acc_addr = 3'd2; acc_rd = 1'b1; end
      S_RD_RX:    begin acc_addr = 3'd0; acc_rd = 1'b1; end
      S_SSO_OFF:  begin acc_addr = 3'd3; acc_data = 16'h0000; end
      default:    begin acc_addr = 3'd0; end
    endcase
    if (!strobe_on) begin
      acc_addr = 3'd0;
      acc_data = 16'h0000;
    end
  end

  assign spi_select        = strobe_on;
  assign spi_mem_addr      = acc_addr;
  assign spi_data_from_cpu = acc_data;
  assign spi_read_n        = !(strobe_on && acc_rd);
  assign spi_write_n       = !(strobe_on && !acc_rd);

  // Next-state, access phase sequencing, polling and response capture.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rrdy_d  = rrdy_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (in_access) phase_d = acc_end ? 2'd0 : phase_q + 2'd1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          rnw_d   = cmd_rnw;
          addr_d  = cmd_addr;
          wdata_d = cmd_rnw ? 8'h00 : cmd_wdata;
          idx_d   = 2'd0;
          err_d   = 1'b0;
          phase_d = 2'd0;
          state_d = S_SSO_ON;
        end
      end
      S_SSO_ON:   if (acc_end) state_d = S_CLR_STAT;
      S_CLR_STAT: if (acc_end) state_d = S_WR_DATA;
      S_WR_DATA: begin
        if (acc_end) begin
          cnt_d   = POLL_LAST;
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        if (phase_q == 2'd1) rrdy_d = spi_data_to_cpu[7];
        if (acc_end) begin
          if (rrdy_q) begin
            state_d = S_RD_RX;
          end else if (cnt_q == '0) begin
            err_d   = 1'b1;
            state_d = S_SSO_OFF;
          end else begin
            cnt_d = cnt_q - TO_W'(1);
          end
        end
      end
      S_RD_RX: begin
        if (phase_q == 2'd1 && idx_q == 2'd3) rdata_d = spi_data_to_cpu[7:0];
        if (acc_end) begin
          if (idx_q == 2'd3) begin
            state_d = S_SSO_OFF;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_WR_DATA;
          end
        end
      end
      S_SSO_OFF: if (acc_end) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= 2'd0;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      rrdy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
      rnw_q   <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rrdy_q  <= rrdy_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Bench for spi_reg_sequencer: behavioural SPI core register model, bus
// access monitor, table of directed commands plus reset / hold corner cases.
module tb_spi_reg_sequencer;

  localparam int TB_TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rnw;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_error;
  logic        spi_select;
  logic [2:0]  spi_mem_addr;
  logic        spi_read_n;
  logic        spi_write_n;
  logic [15:0] spi_data_from_cpu;
  logic [15:0] spi_data_to_cpu;

  always #5 clk = ~clk;

  spi_reg_sequencer #(.POLL_TIMEOUT(TB_TO), .TO_W(13)) u_dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .spi_select(spi_select), .spi_mem_addr(spi_mem_addr),
    .spi_read_n(spi_read_n), .spi_write_n(spi_write_n),
    .spi_data_from_cpu(spi_data_from_cpu), .spi_data_to_cpu(spi_data_to_cpu)
  );

  typedef struct {
    logic        rnw;
    logic [2:0]  addr;
    logic [15:0] data;
  } acc_t;

  typedef struct {
    logic        rnw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          polls;      // status reads returning RRDY=0 before RRDY=1
    bit          stuck;      // RRDY never sets
    logic [7:0]  rx3;        // slave byte returned during frame byte 3
    logic [7:0]  exp_rdata;
    logic        exp_err;
    int          exp_lat;    // cycles from accept to rsp_valid, inclusive
  } vec_t;

  acc_t log_q[$];
  acc_t exp_q[$];

  int n_vec = 0;
  int n_miss = 0;
  int frames_done = 0;
  int log_base = 0;

  // core model state (written only by the monitor process)
  int          wr_cnt = 0;
  int          poll_cnt = 0;
  int          act_cnt = 0;
  int          tim_err = 0;
  int          rsp_cnt = 0;
  logic [2:0]  a0;
  logic [15:0] d0;
  logic        rn0;

  // model configuration (written only by the stimulus process)
  int          cfg_polls = 0;
  bit          cfg_stuck = 1'b0;
  logic [7:0]  cfg_rx3 = 8'h00;

  function automatic logic [7:0] rx_byte(input int k, input logic [7:0] r3);
    logic [7:0] b;
    b = 8'hE0 + 8'(k);
    return (k == 3) ? r3 : b;
  endfunction

  // Core read-data model: status shows RRDY after the configured number of
  // empty polls, rxdata returns a per-byte pattern.
  always_comb begin
    spi_data_to_cpu = 16'h0000;
    if (spi_mem_addr == 3'd2)
      spi_data_to_cpu = (!cfg_stuck && poll_cnt >= cfg_polls) ? 16'h0080 : 16'h0000;
    else if (spi_mem_addr == 3'd0)
      spi_data_to_cpu = {8'h00, rx_byte(wr_cnt - 1, cfg_rx3)};
  end

  // Bus monitor: logs each access, checks 2-cycle strobe, stable address and
  // data, and the idle cycle that must follow; advances the core model.
  always @(posedge clk) begin
    if (reset) begin
      act_cnt  <= 0;
      wr_cnt   <= 0;
      poll_cnt <= 0;
    end else if (spi_select && (!spi_read_n || !spi_write_n)) begin
      if (act_cnt == 0) begin
        a0      <= spi_mem_addr;
        d0      <= spi_data_from_cpu;
        rn0     <= !spi_read_n;
        act_cnt <= 1;
      end else if (act_cnt == 1) begin
        if (spi_mem_addr != a0 || spi_data_from_cpu != d0 || (!spi_read_n) != rn0)
          tim_err <= tim_err + 1;
        log_q.push_back('{rn0, a0, rn0 ? spi_data_to_cpu : d0});
        act_cnt <= 2;
        if (!rn0 && a0 == 3'd3 && d0 == 16'h0400) begin
          wr_cnt   <= 0;
          poll_cnt <= 0;
        end else if (!rn0 && a0 == 3'd1) begin
          wr_cnt   <= wr_cnt + 1;
          poll_cnt <= 0;
        end else if (rn0 && a0 == 3'd2) begin
          poll_cnt <= poll_cnt + 1;
        end
      end else begin
        tim_err <= tim_err + 1;
        act_cnt <= act_cnt + 1;
      end
    end else begin
      if (act_cnt == 1) tim_err <= tim_err + 1;
      act_cnt <= 0;
    end
  end

  always @(posedge clk) begin
    if (!reset && rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic build_exp(input vec_t v);
    logic [7:0] b [4];
    b[0] = v.rnw ? 8'h82 : 8'h02;
    b[1] = v.addr[15:8];
    b[2] = v.addr[7:0];
    b[3] = v.rnw ? 8'h00 : v.wdata;
    exp_q.delete();
    exp_q.push_back('{1'b0, 3'd3, 16'h0400});
    exp_q.push_back('{1'b0, 3'd2, 16'h0000});
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back('{1'b0, 3'd1, {8'h00, b[k]}});
      if (v.stuck) begin
        for (int p = 0; p < TB_TO; p++) exp_q.push_back('{1'b1, 3'd2, 16'h0000});
        break;
      end
      for (int p = 0; p < v.polls; p++) exp_q.push_back('{1'b1, 3'd2, 16'h0000});
      exp_q.push_back('{1'b1, 3'd2, 16'h0080});
      exp_q.push_back('{1'b1, 3'd0, {8'h00, rx_byte(k, v.rx3)}});
    end
    exp_q.push_back('{1'b0, 3'd3, 16'h0000});
  endtask

  task automatic cmp_log(input string tag);
    int n;
    int bad;
    n = log_q.size() - log_base;
    bad = -1;
    check({tag, " bus access count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      if (bad < 0 && (log_q[log_base+i].rnw !== exp_q[i].rnw ||
                      log_q[log_base+i].addr !== exp_q[i].addr ||
                      log_q[log_base+i].data !== exp_q[i].data))
        bad = i;
    end
    n_vec++;
    if (bad >= 0) begin
      n_miss++;
      $display("FAIL %s bus access %0d: got rnw=%0d addr=%0d data=%h expected rnw=%0d addr=%0d data=%h",
               tag, bad, log_q[log_base+bad].rnw, log_q[log_base+bad].addr, log_q[log_base+bad].data,
               exp_q[bad].rnw, exp_q[bad].addr, exp_q[bad].data);
    end
  endtask

  // Wait for cmd_ready, offer the command, return after the accepting edge.
  task automatic start_cmd(input vec_t v, input bit hold, input string tag, output int waited);
    waited = 0;
    while (!cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) check({tag, " cmd_ready wait"}, cmd_ready, 1);
    check({tag, " rsp_valid pulses so far"}, rsp_cnt, frames_done);
    cfg_polls = v.polls;
    cfg_stuck = v.stuck;
    cfg_rx3   = v.rx3;
    build_exp(v);
    log_base  = log_q.size();
    cmd_rnw   = v.rnw;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_valid = 1'b1;
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    check({tag, " cmd_ready after accept"}, cmd_ready, 0);
    check({tag, " rsp_error cleared on accept"}, rsp_error, 0);
  endtask

  // Wait (bounded) for rsp_valid and check the whole frame.
  task automatic finish_cmd(input vec_t v, input string tag);
    int lat;
    lat = 1;
    while (!rsp_valid && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " rsp_error"}, rsp_error, v.exp_err);
    check({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
    check({tag, " cmd_ready in DONE"}, cmd_ready, 0);
    cmp_log(tag);
    check({tag, " strobe timing errors"}, tim_err, 0);
    frames_done++;
  endtask

  vec_t tbl [6];
  vec_t v_h1, v_h2, v_abort, v_after;
  int   w;
  int   n;

  initial begin
    //          rnw   addr      wdata  polls stuck rx3    exp_rd exp_err lat
    tbl[0] = '{1'b0, 16'h3000, 8'hA5, 0, 1'b0, 8'h11, 8'h11, 1'b0, 46};
    tbl[1] = '{1'b1, 16'h1234, 8'hFF, 0, 1'b0, 8'h5C, 8'h5C, 1'b0, 46};
    tbl[2] = '{1'b0, 16'hBEEF, 8'h3C, 2, 1'b0, 8'h77, 8'h77, 1'b0, 70};
    tbl[3] = '{1'b1, 16'h00FF, 8'h00, 1, 1'b0, 8'hA1, 8'hA1, 1'b0, 58};
    tbl[4] = '{1'b1, 16'h4455, 8'h00, 0, 1'b1, 8'h99, 8'hA1, 1'b1, 37};
    tbl[5] = '{1'b0, 16'h7001, 8'h0F, 0, 1'b0, 8'hC3, 8'hC3, 1'b0, 46};
    v_h1    = '{1'b1, 16'hABCD, 8'h00, 0, 1'b0, 8'h9E, 8'h9E, 1'b0, 46};
    v_h2    = '{1'b0, 16'h5A5A, 8'h66, 1, 1'b0, 8'h42, 8'h42, 1'b0, 58};
    v_abort = '{1'b1, 16'h2468, 8'h00, 5, 1'b0, 8'h00, 8'h00, 1'b0, 0};
    v_after = '{1'b0, 16'h1357, 8'h81, 0, 1'b0, 8'h3D, 8'h3D, 1'b0, 46};

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_rnw = 1'b0;
    cmd_addr = 16'h0000;
    cmd_wdata = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset cmd_ready", cmd_ready, 1);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_rdata", rsp_rdata, 0);
    check("reset rsp_error", rsp_error, 0);
    check("reset strobes {sel,rd_n,wr_n}", {spi_select, spi_read_n, spi_write_n}, 3'b011);
    check("reset mem_addr", spi_mem_addr, 0);
    check("reset data_from_cpu", spi_data_from_cpu, 0);

    for (int i = 0; i < 6; i++) begin
      start_cmd(tbl[i], 1'b0, $sformatf("v%0d", i), w);
      finish_cmd(tbl[i], $sformatf("v%0d", i));
    end

    // cmd_valid held across a frame: one frame per accept, next accept
    // lands in the IDLE cycle right after DONE.
    start_cmd(v_h1, 1'b1, "hold1", w);
    finish_cmd(v_h1, "hold1");
    start_cmd(v_h2, 1'b0, "hold2", w);
    check("hold2 accept one cycle after rsp_valid", w, 1);
    finish_cmd(v_h2, "hold2");

    // Reset while polling for byte 2.
    start_cmd(v_abort, 1'b0, "abort", w);
    n = 0;
    while (!(wr_cnt == 3 && poll_cnt >= 1) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort reached byte 2 poll", (wr_cnt == 3 && poll_cnt >= 1), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort cmd_ready after reset", cmd_ready, 1);
    check("abort strobes idle after reset", {spi_select, spi_read_n, spi_write_n}, 3'b011);
    check("abort rsp_valid after reset", rsp_valid, 0);
    check("abort rsp_rdata after reset", rsp_rdata, 0);
    start_cmd(v_after, 1'b0, "after_reset", w);
    finish_cmd(v_after, "after_reset");

    repeat (3) @(negedge clk);
    check("total rsp_valid pulses", rsp_cnt, frames_done);
    check("idle after last frame", {cmd_ready, spi_select}, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
